// File: rtl/cortez_pkg.sv
// Shared definitions for the hidden-layer collector: stream FSM encoding and index sizing.
package cortez_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOADED = 2'd1,
        STREAM = 2'd2
    } state_e;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n < 2) ? 32'd1 : 32'($clog2(n));
    endfunction

endpackage

// File: rtl/hl_capture_bank.sv
// Capture bank: first-result-wins storage per neuron, overflow aggregation and collision flag.
module hl_capture_bank
    import cortez_pkg::*;
#(
    parameter int unsigned NUM_NEURONS = 8,
    parameter int unsigned WIDTH       = 8
) (
    input  logic                         clk_i,
    input  logic                         rstn_i,
    input  logic [NUM_NEURONS*WIDTH-1:0] value_i,
    input  logic [NUM_NEURONS-1:0]       valid_i,
    input  logic [NUM_NEURONS-1:0]       ovf_i,
    input  logic                         xfer_i,
    output logic [NUM_NEURONS*WIDTH-1:0] data_o,
    output logic                         ovf_o,
    output logic                         full_o_c,
    output logic                         ready_o,
    output logic                         collision_o
);

    logic [NUM_NEURONS-1:0]       mask_q, mask_d;
    logic [NUM_NEURONS*WIDTH-1:0] data_q, data_d;
    logic                         ovf_q, ovf_d;
    logic                         ready_q, ready_d;
    logic                         coll_q, coll_d;

    // Collisions are judged against the pre-edge mask, so a transfer never hides one.
    always_comb begin
        mask_d = mask_q;
        data_d = data_q;
        ovf_d  = ovf_q;
        for (int i = 0; i < NUM_NEURONS; i++) begin
            if (valid_i[i] && !mask_q[i]) begin
                mask_d[i]                  = 1'b1;
                data_d[i*WIDTH +: WIDTH]   = value_i[i*WIDTH +: WIDTH];
                ovf_d                      = ovf_d | ovf_i[i];
            end
        end
        if (xfer_i) begin
            mask_d = '0;
            ovf_d  = 1'b0;
        end
        ready_d = ~|mask_d;
        coll_d  = coll_q | (|(valid_i & mask_q));
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            mask_q  <= '0;
            data_q  <= '0;
            ovf_q   <= 1'b0;
            ready_q <= 1'b1;
            coll_q  <= 1'b0;
        end else begin
            mask_q  <= mask_d;
            data_q  <= data_d;
            ovf_q   <= ovf_d;
            ready_q <= ready_d;
            coll_q  <= coll_d;
        end
    end

    assign data_o      = data_q;
    assign ovf_o       = ovf_q;
    assign full_o_c    = &mask_q;
    assign ready_o     = ready_q;
    assign collision_o = coll_q;

endmodule

// File: rtl/hl_layer_collector.sv
// Collects parallel neuron results and replays them as a contiguous serial stream (ping-pong banks).
module hl_layer_collector
    import cortez_pkg::*;
#(
    parameter int unsigned NUM_NEURONS = 8,
    parameter int unsigned WIDTH       = 8
) (
    input  logic                         CLK,
    input  logic                         RSTN,
    input  logic [NUM_NEURONS*WIDTH-1:0] VALUE_IN,
    input  logic [NUM_NEURONS-1:0]       VALID_IN,
    input  logic [NUM_NEURONS-1:0]       OVERFLOW_IN,
    output logic                         CAPTURE_READY,
    input  logic                         DOWN_READY,
    output logic signed [WIDTH-1:0]      VALUE_OUT,
    output logic                         VALID_OUT,
    output logic                         LAST,
    output logic                         OVERFLOW_OUT,
    output logic                         COLLISION
);

    localparam int unsigned      IDX_W    = idx_width(NUM_NEURONS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NEURONS - 1);

    state_e                       state_q, state_d;
    logic [IDX_W-1:0]             idx_q, idx_d;
    logic [NUM_NEURONS*WIDTH-1:0] str_data_q, str_data_d;
    logic                         str_ovf_q, str_ovf_d;
    logic                         valid_q, valid_d;
    logic [WIDTH-1:0]             value_q, value_d;
    logic                         last_q, last_d;
    logic                         ovf_out_q, ovf_out_d;

    logic                         xfer_c;
    logic [NUM_NEURONS*WIDTH-1:0] cap_data;
    logic                         cap_ovf;
    logic                         cap_full_c;

    hl_capture_bank #(
        .NUM_NEURONS (NUM_NEURONS),
        .WIDTH       (WIDTH)
    ) u_cap (
        .clk_i       (CLK),
        .rstn_i      (RSTN),
        .value_i     (VALUE_IN),
        .valid_i     (VALID_IN),
        .ovf_i       (OVERFLOW_IN),
        .xfer_i      (xfer_c),
        .data_o      (cap_data),
        .ovf_o       (cap_ovf),
        .full_o_c    (cap_full_c),
        .ready_o     (CAPTURE_READY),
        .collision_o (COLLISION)
    );

    // Next state plus registered beat outputs derived from the next state/index.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        str_data_d = str_data_q;
        str_ovf_d  = str_ovf_q;
        xfer_c     = 1'b0;
        value_d    = '0;
        case (state_q)
            IDLE: begin
                if (cap_full_c) begin
                    xfer_c     = 1'b1;
                    str_data_d = cap_data;
                    str_ovf_d  = cap_ovf;
                    state_d    = LOADED;
                end
            end
            LOADED: begin
                if (DOWN_READY) begin
                    state_d = STREAM;
                    idx_d   = '0;
                end
            end
            STREAM: begin
                if (idx_q == LAST_IDX) begin
                    state_d = IDLE;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
            end
        endcase
        valid_d   = (state_d == STREAM);
        last_d    = valid_d && (idx_d == LAST_IDX);
        ovf_out_d = valid_d && str_ovf_q;
        if (valid_d) begin
            for (int i = 0; i < NUM_NEURONS; i++) begin
                if (idx_d == IDX_W'(i)) begin
                    value_d = str_data_q[i*WIDTH +: WIDTH];
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            str_data_q <= '0;
            str_ovf_q  <= 1'b0;
            valid_q    <= 1'b0;
            value_q    <= '0;
            last_q     <= 1'b0;
            ovf_out_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            str_data_q <= str_data_d;
            str_ovf_q  <= str_ovf_d;
            valid_q    <= valid_d;
            value_q    <= value_d;
            last_q     <= last_d;
            ovf_out_q  <= ovf_out_d;
        end
    end

    assign VALID_OUT    = valid_q;
    assign VALUE_OUT    = value_q;
    assign LAST         = last_q;
    assign OVERFLOW_OUT = ovf_out_q;

endmodule

// File: tb/tb_hl_layer_collector.sv
// Directed + randomized bench for hl_layer_collector with a first-write-wins batch model.
module tb_hl_layer_collector;

    localparam int unsigned N = 8;
    localparam int unsigned W = 8;

    logic           CLK = 1'b0;
    logic           rstn;
    logic [N*W-1:0] value_in;
    logic [N-1:0]   valid_in;
    logic [N-1:0]   ovf_in;
    logic           down_ready;
    logic           capture_ready;
    logic [W-1:0]   value_out;
    logic           valid_out;
    logic           last_out;
    logic           ovf_out;
    logic           collision;

    int nerr = 0;
    int nchk = 0;

    always #5 CLK = ~CLK;

    hl_layer_collector #(.NUM_NEURONS(N), .WIDTH(W)) dut (
        .CLK           (CLK),
        .RSTN          (rstn),
        .VALUE_IN      (value_in),
        .VALID_IN      (valid_in),
        .OVERFLOW_IN   (ovf_in),
        .CAPTURE_READY (capture_ready),
        .DOWN_READY    (down_ready),
        .VALUE_OUT     (value_out),
        .VALID_OUT     (valid_out),
        .LAST          (last_out),
        .OVERFLOW_OUT  (ovf_out),
        .COLLISION     (collision)
    );

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [N-1:0] v, input logic [N-1:0] o, input logic [N*W-1:0] d);
        valid_in = v;
        ovf_in   = o;
        value_in = d;
        tick();
        valid_in = '0;
        ovf_in   = '0;
    endtask

    function automatic logic [N*W-1:0] rnd_data();
        return {$urandom, $urandom};
    endfunction

    // Waits for the stream, checks latency, then all beats and the idle state after it.
    task automatic check_stream(input logic [N*W-1:0] exp, input logic eovf, input int lat,
                                input int drop_at);
        int n = 0;
        while (valid_out !== 1'b1 && n < 64) begin
            tick();
            n++;
        end
        chk("latency", 64'(n), 64'(lat));
        if (valid_out !== 1'b1) return;
        for (int k = 0; k < N; k++) begin
            chk($sformatf("beat%0d_value", k), 64'(value_out), 64'(exp[k*W +: W]));
            chk($sformatf("beat%0d_valid", k), 64'(valid_out), 64'd1);
            chk($sformatf("beat%0d_last", k), 64'(last_out), 64'(k == N - 1));
            chk($sformatf("beat%0d_ovf", k), 64'(ovf_out), 64'(eovf));
            if (k == drop_at) down_ready = 1'b0;
            tick();
        end
        chk("end_valid", 64'(valid_out), 64'd0);
        chk("end_value", 64'(value_out), 64'd0);
        chk("end_ovf", 64'(ovf_out), 64'd0);
        chk("end_last", 64'(last_out), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N*W-1:0] a_data, b_data, d;
        logic [N-1:0]   m_mask, v, o;
        logic           m_ovf, m_coll, eovf;
        int             guard, seen;

        rstn = 1'b0; valid_in = '0; ovf_in = '0; value_in = '0; down_ready = 1'b1;
        tick(); tick(); tick();
        chk("rst_valid", 64'(valid_out), 64'd0);
        chk("rst_value", 64'(value_out), 64'd0);
        chk("rst_last", 64'(last_out), 64'd0);
        chk("rst_ovf", 64'(ovf_out), 64'd0);
        chk("rst_coll", 64'(collision), 64'd0);
        chk("rst_cap_ready", 64'(capture_ready), 64'd1);
        rstn = 1'b1;
        tick();

        // Single batch 0x01..0x08 strobed together.
        for (int k = 0; k < N; k++) a_data[k*W +: W] = W'(k + 1);
        drive('1, '0, a_data);
        chk("single_cap_ready", 64'(capture_ready), 64'd0);
        check_stream(a_data, 1'b0, 2, -1);
        chk("single_cap_ready_after", 64'(capture_ready), 64'd1);

        // Staggered capture 7..0 with overflow on neuron 3.
        a_data = rnd_data();
        for (int i = N - 1; i >= 0; i--) drive(N'(1) << i, (i == 3) ? N'(8) : N'(0), a_data);
        check_stream(a_data, 1'b1, 2, -1);

        // Back-pressure then drop DOWN_READY mid-stream.
        down_ready = 1'b0;
        a_data = rnd_data();
        drive('1, '0, a_data);
        seen = 0;
        for (int c = 0; c < 10; c++) begin
            if (valid_out !== 1'b0) seen++;
            tick();
        end
        chk("backpressure_no_valid", 64'(seen), 64'd0);
        down_ready = 1'b1;
        check_stream(a_data, 1'b0, 1, 3);
        down_ready = 1'b1;

        // Ping-pong: capture B one neuron per beat while A streams.
        a_data = rnd_data();
        for (int k = 0; k < N; k++) b_data[k*W +: W] = W'(8'h10 + k);
        drive('1, '0, a_data);
        tick(); tick();
        for (int k = 0; k < N; k++) begin
            chk($sformatf("pp_a_beat%0d", k), 64'(value_out), 64'(a_data[k*W +: W]));
            chk($sformatf("pp_a_valid%0d", k), 64'(valid_out), 64'd1);
            if (k > 0) chk($sformatf("pp_cap_ready%0d", k), 64'(capture_ready), 64'd0);
            valid_in = N'(1) << k;
            value_in = b_data;
            tick();
        end
        valid_in = '0;
        check_stream(b_data, 1'b0, 2, -1);

        // Random strobe patterns against the first-write-wins model.
        m_coll = 1'b0;
        for (int b = 0; b < 3; b++) begin
            m_mask = '0; m_ovf = 1'b0; guard = 0;
            while (m_mask != '1 && guard < 40) begin
                v = N'($urandom); o = N'($urandom); d = rnd_data();
                for (int i = 0; i < N; i++) begin
                    if (v[i] && m_mask[i]) m_coll = 1'b1;
                    else if (v[i]) begin
                        m_mask[i] = 1'b1;
                        a_data[i*W +: W] = d[i*W +: W];
                        m_ovf = m_ovf | o[i];
                    end
                end
                drive(v, o, d);
                guard++;
            end
            if (m_mask != '1) begin
                d = rnd_data();
                for (int i = 0; i < N; i++) if (!m_mask[i]) a_data[i*W +: W] = d[i*W +: W];
                drive(~m_mask, '0, d);
            end
            eovf = m_ovf;
            check_stream(a_data, eovf, 2, -1);
            chk("rand_collision", 64'(collision), 64'(m_coll));
        end

        // Collision on neuron 2: first value kept, flag sticky.
        a_data = rnd_data();
        a_data[2*W +: W] = 8'h05;
        drive(N'(4), '0, a_data);
        d = a_data;
        d[2*W +: W] = 8'h7F;
        drive(N'(4), '0, d);
        chk("collision_set", 64'(collision), 64'd1);
        drive(~N'(4), '0, a_data);
        check_stream(a_data, 1'b0, 2, -1);
        chk("collision_sticky", 64'(collision), 64'd1);

        // Reset at beat 4 with a partial capture pending.
        a_data = rnd_data();
        drive('1, '0, a_data);
        tick(); tick();
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("rst_mid_beat%0d", k), 64'(value_out), 64'(a_data[k*W +: W]));
            if (k == 0) valid_in = N'(1);
            tick();
            valid_in = '0;
        end
        chk("rst_mid_beat4_valid", 64'(valid_out), 64'd1);
        chk("rst_mid_partial", 64'(capture_ready), 64'd0);
        rstn = 1'b0;
        tick();
        chk("rst_mid_valid", 64'(valid_out), 64'd0);
        chk("rst_mid_coll", 64'(collision), 64'd0);
        chk("rst_mid_cap_ready", 64'(capture_ready), 64'd1);
        rstn = 1'b1;
        seen = 0;
        for (int c = 0; c < 12; c++) begin
            if (valid_out !== 1'b0) seen++;
            tick();
        end
        chk("rst_mid_no_beats", 64'(seen), 64'd0);
        chk("rst_mid_cap_ready_hold", 64'(capture_ready), 64'd1);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
